// File: rtl/hf14a_pkg.sv
// rtl/hf14a_pkg.sv - shared constants and FSM state type for the ISO14443A reader sequencer
package hf14a_pkg;

    localparam logic [2:0] SNIFFER       = 3'b000;
    localparam logic [2:0] READER_LISTEN = 3'b011;
    localparam logic [2:0] READER_MOD    = 3'b100;

    localparam int SLOT_LEN = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TX,
        ST_GUARD,
        ST_LISTEN,
        ST_RXEND
    } state_e;

endpackage

// File: rtl/hf_slot_timer.sv
// rtl/hf_slot_timer.sv - 16-cycle slot counter with an end-of-slot strobe
module hf_slot_timer
    import hf14a_pkg::*;
(
    input  logic ck_1356meg,
    input  logic nrst,
    input  logic run_i,
    output logic slot_end_o
);

    logic [3:0] slot_cnt_q;
    logic [3:0] slot_cnt_d;

    // Held at zero while idle so the first slot of an exchange is always full length.
    always_comb begin
        slot_cnt_d = '0;
        if (run_i) begin
            slot_cnt_d = slot_cnt_q + 4'd1;
        end
    end

    always_ff @(negedge ck_1356meg or negedge nrst) begin
        if (!nrst) begin
            slot_cnt_q <= '0;
        end else begin
            slot_cnt_q <= slot_cnt_d;
        end
    end

    assign slot_end_o = run_i && (slot_cnt_q == 4'(SLOT_LEN - 1));

endmodule

// File: rtl/hf14a_reader_seq.sv
// rtl/hf14a_reader_seq.sv - reader exchange sequencer: TX pauses, frame guard, listen, end of reception
module hf14a_reader_seq
    import hf14a_pkg::*;
#(
    parameter int GUARD_SLOTS   = 72,
    parameter int TIMEOUT_SLOTS = 1024,
    parameter int RX_END_SLOTS  = 16
) (
    input  logic        ck_1356meg,
    input  logic        nrst,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] tx_data,
    input  logic [4:0]  tx_len,
    input  logic        curbit,
    output logic [2:0]  mod_type,
    output logic        mod_sig,
    output logic        busy,
    output logic        rx_seen,
    output logic        done,
    output logic        timeout
);

    localparam int GW = $clog2(GUARD_SLOTS + 1);
    localparam int TW = $clog2(TIMEOUT_SLOTS + 1);
    localparam int QW = $clog2(RX_END_SLOTS + 1);
    localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_SLOTS - 1);
    localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_SLOTS - 1);
    localparam logic [TW-1:0] TO_MAX     = TW'(TIMEOUT_SLOTS);
    localparam logic [QW-1:0] QUIET_LAST = QW'(RX_END_SLOTS - 1);

    state_e        state_q, state_d;
    logic [15:0]   tx_q, tx_d;
    logic [3:0]    idx_q, idx_d;
    logic [GW-1:0] guard_q, guard_d;
    logic [TW-1:0] to_q, to_d;
    logic [QW-1:0] quiet_q, quiet_d;
    logic          rx_seen_q, rx_seen_d;
    logic          timeout_q, timeout_d;
    logic          slot_end;
    logic [4:0]    len_c;

    hf_slot_timer u_slot_timer (
        .ck_1356meg (ck_1356meg),
        .nrst       (nrst),
        .run_i      (busy),
        .slot_end_o (slot_end)
    );

    assign len_c = (tx_len > 5'd16) ? 5'd16 : tx_len;

    always_comb begin
        state_d   = state_q;
        tx_d      = tx_q;
        idx_d     = idx_q;
        guard_d   = guard_q;
        to_d      = to_q;
        quiet_d   = quiet_q;
        rx_seen_d = rx_seen_q;
        timeout_d = 1'b0;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        tx_d      = tx_data;
                        idx_d     = 4'(len_c - 5'd1);
                        guard_d   = '0;
                        to_d      = '0;
                        quiet_d   = '0;
                        rx_seen_d = 1'b0;
                        state_d   = (len_c != 5'd0) ? ST_TX : ST_GUARD;
                    end
                end
                ST_TX: begin
                    if (slot_end) begin
                        if (idx_q == 4'd0) begin
                            state_d = ST_GUARD;
                        end else begin
                            idx_d = idx_q - 4'd1;
                        end
                    end
                end
                ST_GUARD: begin
                    if (slot_end) begin
                        if (guard_q == GUARD_LAST) begin
                            state_d = ST_LISTEN;
                        end else begin
                            guard_d = guard_q + GW'(1);
                        end
                    end
                end
                ST_LISTEN: begin
                    if (slot_end) begin
                        if (to_q != TO_MAX) begin
                            to_d = to_q + TW'(1);
                        end
                        // Tag activity in the last timeout slot takes priority over the timeout.
                        if (curbit) begin
                            rx_seen_d = 1'b1;
                            quiet_d   = '0;
                        end else if (rx_seen_q) begin
                            if (quiet_q == QUIET_LAST) begin
                                state_d = ST_RXEND;
                            end else begin
                                quiet_d = quiet_q + QW'(1);
                            end
                        end else if (to_q == TO_LAST) begin
                            state_d   = ST_IDLE;
                            timeout_d = 1'b1;
                        end
                    end
                end
                ST_RXEND: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(negedge ck_1356meg or negedge nrst) begin
        if (!nrst) begin
            state_q   <= ST_IDLE;
            tx_q      <= '0;
            idx_q     <= '0;
            guard_q   <= '0;
            to_q      <= '0;
            quiet_q   <= '0;
            rx_seen_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_q      <= tx_d;
            idx_q     <= idx_d;
            guard_q   <= guard_d;
            to_q      <= to_d;
            quiet_q   <= quiet_d;
            rx_seen_q <= rx_seen_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        mod_type = SNIFFER;
        unique case (state_q)
            ST_TX:                         mod_type = READER_MOD;
            ST_GUARD, ST_LISTEN, ST_RXEND: mod_type = READER_LISTEN;
            default:                       mod_type = SNIFFER;
        endcase
    end

    assign mod_sig = (state_q == ST_TX) && tx_q[idx_q];
    assign busy    = (state_q != ST_IDLE);
    assign done    = (state_q == ST_RXEND);
    assign timeout = timeout_q;
    assign rx_seen = rx_seen_q;

endmodule
